mux_pipe_reg: RTL and testbench

Parametrised N-way, W-bit select-and-register stage for the pipelined MIPS datapath. It generalises the 2:1 5-bit destination-register mux to any input count and width. The result is registered directly into a pipeline latch with stall, flush/bubble, valid tracking and out-of-range select detection. Typical uses are the EX/MEM destination-register select (rt/rd/$31) and the forwarding-operand select into the ALU input latch.

---
 rtl/mips_pipe_pkg.sv | 12 +
 rtl/mux_nway.sv | 23 ++
 rtl/mux_pipe_reg.sv | 78 +++++++
 tb/tb_mux_pipe_reg.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline select/register stages.
package mips_pipe_pkg;

    localparam int REG_SEL_RT = 0;
    localparam int REG_SEL_RD = 1;
    localparam int REG_SEL_RA = 2;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nway.sv
// Combinational N-way W-bit select; out-of-range selects yield zero.
module mux_nway
    import mips_pipe_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int WIDTH = 5,
    localparam int SEL_W = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        mux_out
);

    always_comb begin
        mux_out = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                mux_out = din[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_pipe_reg.sv
// Select-and-register pipeline stage with stall, flush, valid and
// sticky out-of-range select detection.
module mux_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int WIDTH = 5,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int SEL_W = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    valid_in,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        dout,
    output logic                    valid_out,
    output logic [SEL_W-1:0]        sel_q,
    output logic                    sel_err
);

    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] dout_d, dout_q;
    logic             valid_d, valid_q;
    logic [SEL_W-1:0] sel_d;
    logic             err_d, err_q;
    logic             sel_oor;

    mux_nway #(
        .NUM_IN (NUM_IN),
        .WIDTH  (WIDTH)
    ) u_mux (
        .din     (din),
        .sel     (sel),
        .mux_out (mux_out)
    );

    // Constant-false when NUM_IN is a power of two
    assign sel_oor = (32'(sel) >= 32'(NUM_IN));

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        err_d   = err_q;
        if (flush) begin
            dout_d  = RESET_VAL;
            valid_d = 1'b0;
            sel_d   = '0;
        end else if (!stall) begin
            dout_d  = mux_out;
            valid_d = valid_in;
            sel_d   = sel;
            err_d   = err_q | (valid_in & sel_oor);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q  <= RESET_VAL;
            valid_q <= 1'b0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    assign dout      = dout_q;
    assign valid_out = valid_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Directed and randomised scoreboard bench for mux_pipe_reg.
module tb_mux_pipe_reg;

    typedef struct {
        logic [31:0] d;
        logic        v;
        logic [1:0]  s;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NUM_IN=3, WIDTH=5
    logic        rst_n_a;
    logic [14:0] din_a;
    logic [1:0]  sel_a;
    logic        vin_a, stall_a, flush_a;
    logic [4:0]  dout_a;
    logic        vout_a;
    logic [1:0]  selq_a;
    logic        err_a;

    // Instance B: NUM_IN=4, WIDTH=32
    logic         rst_n_b;
    logic [127:0] din_b;
    logic [1:0]   sel_b;
    logic         vin_b, stall_b, flush_b;
    logic [31:0]  dout_b;
    logic         vout_b;
    logic [1:0]   selq_b;
    logic         err_b;

    localparam logic [4:0]  RV_A = 5'h1F;
    localparam logic [31:0] RV_B = 32'hDEAD_BEEF;
    localparam logic [14:0] DIN_A0 = {5'd31, 5'd17, 5'd9};

    mux_pipe_reg #(.NUM_IN(3), .WIDTH(5), .RESET_VAL(RV_A)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n_a),
        .din       (din_a),
        .sel       (sel_a),
        .valid_in  (vin_a),
        .stall     (stall_a),
        .flush     (flush_a),
        .dout      (dout_a),
        .valid_out (vout_a),
        .sel_q     (selq_a),
        .sel_err   (err_a)
    );

    mux_pipe_reg #(.NUM_IN(4), .WIDTH(32), .RESET_VAL(RV_B)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n_b),
        .din       (din_b),
        .sel       (sel_b),
        .valid_in  (vin_b),
        .stall     (stall_b),
        .flush     (flush_b),
        .dout      (dout_b),
        .valid_out (vout_b),
        .sel_q     (selq_b),
        .sel_err   (err_b)
    );

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input string tag, input logic rst,
                          input logic [1:0] s, input logic v,
                          input logic st, input logic fl,
                          input logic [4:0] ed, input logic ev,
                          input logic [1:0] es, input logic ee);
        exp_t e;
        exp_t got;
        rst_n_a = rst; sel_a = s; vin_a = v; stall_a = st; flush_a = fl;
        e.d = {27'd0, ed}; e.v = ev; e.s = es; e.e = ee;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".dout"}, {27'd0, dout_a}, got.d);
        chk({tag, ".valid"}, {31'd0, vout_a}, {31'd0, got.v});
        chk({tag, ".sel_q"}, {30'd0, selq_a}, {30'd0, got.s});
        chk({tag, ".sel_err"}, {31'd0, err_a}, {31'd0, got.e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t m;
        exp_t got;
        logic r;

        din_a = DIN_A0;
        rst_n_b = 1'b0; din_b = '0; sel_b = '0;
        vin_b = 1'b0; stall_b = 1'b0; flush_b = 1'b0;
        #1;

        // Reset held for two edges
        step_a("rst0", 0, 2'd2, 1, 0, 0, RV_A, 0, 0, 0);
        step_a("rst1", 0, 2'd1, 1, 0, 0, RV_A, 0, 0, 0);
        // Select sweep
        step_a("sw0", 1, 2'd0, 1, 0, 0, 5'd9, 1, 0, 0);
        step_a("sw1", 1, 2'd1, 1, 0, 0, 5'd17, 1, 1, 0);
        step_a("sw2", 1, 2'd2, 1, 0, 0, 5'd31, 1, 2, 0);
        // Stall holds 17 while inputs change
        step_a("ld17", 1, 2'd1, 1, 0, 0, 5'd17, 1, 1, 0);
        din_a = {5'd3, 5'd4, 5'd5};
        step_a("st0", 1, 2'd2, 0, 1, 0, 5'd17, 1, 1, 0);
        step_a("st1", 1, 2'd2, 1, 1, 0, 5'd17, 1, 1, 0);
        step_a("st2", 1, 2'd2, 1, 1, 0, 5'd17, 1, 1, 0);
        din_a = DIN_A0;
        step_a("unst", 1, 2'd2, 1, 0, 0, 5'd31, 1, 2, 0);
        // Flush beats stall, next load revalidates
        step_a("flst", 1, 2'd0, 1, 1, 1, RV_A, 0, 0, 0);
        step_a("rld", 1, 2'd0, 1, 0, 0, 5'd9, 1, 0, 0);
        step_a("inv", 1, 2'd1, 0, 0, 0, 5'd17, 0, 1, 0);
        // Out-of-range select
        step_a("oor_nv", 1, 2'd3, 0, 0, 0, 5'd0, 0, 3, 0);
        step_a("oor_v", 1, 2'd3, 1, 0, 0, 5'd0, 1, 3, 1);
        step_a("sticky_ld", 1, 2'd0, 1, 0, 0, 5'd9, 1, 0, 1);
        step_a("sticky_fl", 1, 2'd1, 1, 0, 1, RV_A, 0, 0, 1);
        step_a("sticky_st", 1, 2'd3, 1, 1, 0, RV_A, 0, 0, 1);
        step_a("rst_mid", 0, 2'd3, 1, 1, 1, RV_A, 0, 0, 0);
        step_a("post_rst", 1, 2'd2, 1, 0, 0, 5'd31, 1, 2, 0);

        // Randomised run on the 4x32 instance against a reference model
        m.d = RV_B; m.v = 1'b0; m.s = 2'd0; m.e = 1'b0;
        for (int i = 0; i < 1003; i++) begin
            r = (i < 2);
            rst_n_b = ~r;
            din_b = {$urandom, $urandom, $urandom, $urandom};
            sel_b = 2'($urandom_range(0, 3));
            vin_b = 1'($urandom_range(0, 1));
            stall_b = ($urandom_range(0, 3) == 0);
            flush_b = ($urandom_range(0, 9) == 0);
            if (r) begin
                m.d = RV_B; m.v = 1'b0; m.s = 2'd0; m.e = 1'b0;
            end else if (flush_b) begin
                m.d = RV_B; m.v = 1'b0; m.s = 2'd0;
            end else if (!stall_b) begin
                m.d = din_b[sel_b*32 +: 32];
                m.v = vin_b;
                m.s = sel_b;
            end
            sb.push_back(m);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            chk("rnd.dout", dout_b, got.d);
            chk("rnd.valid", {31'd0, vout_b}, {31'd0, got.v});
            chk("rnd.sel_q", {30'd0, selq_b}, {30'd0, got.s});
            chk("rnd.sel_err", {31'd0, err_b}, {31'd0, got.e});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
